// File: rtl/present_pkg.sv
// Shared constants, FSM state type and S-box lookup for the PRESENT-80 encryption core.
package present_pkg;

    localparam int unsigned BlockW    = 64;
    localparam int unsigned KeyW      = 80;
    localparam int unsigned NumRounds = 31;

    // Nibble n of the table holds S(n); entry 0 sits in bits [3:0].
    localparam logic [63:0] SboxTable = 64'h21748FE3DA09B65C;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SboxTable[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/present_player_enc.sv
// PRESENT bit permutation: bit i moves to 16*i mod 63, bit 63 stays in place.
module present_player_enc
    import present_pkg::*;
(
    input  logic [BlockW-1:0] state_i,
    output logic [BlockW-1:0] state_o
);

    always_comb begin
        state_o = '0;
        for (int i = 0; i < 63; i++) begin
            state_o[(16 * i) % 63] = state_i[i];
        end
        state_o[63] = state_i[63];
    end

endmodule

// File: rtl/present80_enc_core.sv
// Iterative PRESENT-80 encryption core: one round per clock, 31 rounds plus a final
// round-key XOR folded into the last round's cycle.
module present80_enc_core
    import present_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BlockW-1:0] plaintext,
    input  logic [KeyW-1:0]   key,
    output logic              busy,
    output logic              done,
    output logic [BlockW-1:0] ciphertext
);

    state_e            fsm_q, fsm_d;
    logic [BlockW-1:0] state_q, state_d;
    logic [BlockW-1:0] ct_q, ct_d;
    logic [KeyW-1:0]   key_q, key_d;
    logic [4:0]        round_q, round_d;

    logic [BlockW-1:0] round_in;
    logic [BlockW-1:0] sbox_out;
    logic [BlockW-1:0] perm_out;
    logic [KeyW-1:0]   key_next;
    logic              last_round;

    assign last_round = (round_q == 5'(NumRounds));
    assign round_in   = state_q ^ key_q[79:16];

    always_comb begin
        sbox_out = '0;
        for (int n = 0; n < 16; n++) begin
            sbox_out[4*n +: 4] = sbox(round_in[4*n +: 4]);
        end
    end

    present_player_enc u_player (
        .state_i (sbox_out),
        .state_o (perm_out)
    );

    // Key schedule for the round being completed; round_q supplies the counter value.
    always_comb begin
        key_next          = {key_q[18:0], key_q[79:19]};
        key_next[79:76]   = sbox(key_next[79:76]);
        key_next[19:15]   = key_next[19:15] ^ round_q;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= StIdle;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            StIdle:  if (start) fsm_d = StRun;
            StRun:   if (last_round) fsm_d = StDone;
            StDone:  fsm_d = StIdle;
            default: fsm_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (fsm_q == StRun);
        done = (fsm_q == StDone);
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        ct_d    = ct_q;
        if (fsm_q == StIdle && start) begin
            state_d = plaintext;
            key_d   = key;
            round_d = 5'd1;
        end else if (fsm_q == StRun) begin
            state_d = perm_out;
            key_d   = key_next;
            round_d = last_round ? round_q : round_q + 5'd1;
            if (last_round) begin
                ct_d = perm_out ^ key_next[79:16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            ct_q    <= ct_d;
        end
    end

    assign ciphertext = ct_q;

endmodule
